// File: rtl/request_arbiter.sv
// request_arbiter: registered N-way valid/ready arbiter.
// Fixed-priority (either direction) or round-robin selection.
package selector_params;
    typedef enum logic [1:0] {
        HIGH_TO_LOW,
        LOW_TO_HIGH,
        ROUND_ROBIN
    } mode_e;
endpackage

package cpu_core_params;
    typedef logic [31:0] cpu_data_t;
endpackage

module request_arbiter #(
    parameter type                   DataType = cpu_core_params::cpu_data_t,
    parameter int                    PORTS    = 4,
    parameter selector_params::mode_e MODE    = selector_params::HIGH_TO_LOW,
    parameter int                    IDX_W    = $clog2(PORTS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [PORTS-1:0]      req_valid,
    input  DataType [PORTS-1:0]   req_data,
    output logic [PORTS-1:0]      req_ready,
    output logic                  out_valid,
    output DataType               out_data,
    output logic [IDX_W-1:0]      out_index,
    input  logic                  out_ready
);
    import selector_params::*;

    logic             out_valid_q, out_valid_d;
    DataType          out_data_q, out_data_d;
    logic [IDX_W-1:0] out_index_q, out_index_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    logic             load_en;
    logic             any_valid;
    logic             grant;
    logic [IDX_W-1:0] winner;

    assign load_en   = !out_valid_q || out_ready;
    assign any_valid = |req_valid;
    assign grant     = load_en && any_valid;

    // Scans run from the lowest-priority end so the last hit wins.
    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        unique case (MODE)
            HIGH_TO_LOW: begin
                for (int i = PORTS - 1; i >= 0; i--) begin
                    if (req_valid[i]) winner = IDX_W'(i);
                end
            end
            LOW_TO_HIGH: begin
                for (int i = 0; i < PORTS; i++) begin
                    if (req_valid[i]) winner = IDX_W'(i);
                end
            end
            default: begin
                for (int k = PORTS - 1; k >= 0; k--) begin
                    idx = int'(rr_ptr_q) + k;
                    if (idx >= PORTS) idx = idx - PORTS;
                    if (req_valid[idx]) winner = IDX_W'(idx);
                end
            end
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (grant && !reset) req_ready[winner] = 1'b1;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        rr_ptr_d    = rr_ptr_q;
        if (load_en) out_valid_d = any_valid;
        if (grant) begin
            out_data_d  = req_data[winner];
            out_index_d = winner;
            if (MODE == ROUND_ROBIN) begin
                if (winner == IDX_W'(PORTS - 1)) rr_ptr_d = '0;
                else                             rr_ptr_d = winner + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_index = out_index_q;

endmodule

// File: tb/tb_request_arbiter.sv
// tb_request_arbiter: one instance per mode, random traffic
// checked by a queue scoreboard against a priority-rule model.
module tb_request_arbiter;
    import selector_params::*;

    localparam int P  = 4;
    localparam int NI = 3;

    typedef struct packed {
        logic [1:0]  idx;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [P-1:0]       rv   [NI];
    logic [P-1:0][31:0] rd   [NI];
    logic [P-1:0]       rr   [NI];
    logic               ov   [NI];
    logic [31:0]        od   [NI];
    logic [1:0]         oi   [NI];
    logic               ordy [NI];

    exp_t exp_q [NI][$];
    int   m_ptr [NI];
    bit   m_ov  [NI];
    int   gnt   [NI];
    int   rr_seen [$];
    int   errors = 0;
    int   checks = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        request_arbiter #(
            .DataType (logic [31:0]),
            .PORTS    (P),
            .MODE     (mode_e'(g))
        ) u_dut (
            .clock     (clk),
            .reset     (rst),
            .req_valid (rv[g]),
            .req_data  (rd[g]),
            .req_ready (rr[g]),
            .out_valid (ov[g]),
            .out_data  (od[g]),
            .out_index (oi[g]),
            .out_ready (ordy[g])
        );

        always @(negedge clk) begin
            #2;
            if (!rst && ov[g]) begin
                if (exp_q[g].size() == 0) begin
                    chk($sformatf("spurious_out%0d", g), 64'(ov[g]), 64'd0);
                end else begin
                    chk($sformatf("out_index%0d", g), 64'(oi[g]),
                        64'(exp_q[g][0].idx));
                    chk($sformatf("out_data%0d", g), 64'(od[g]),
                        64'(exp_q[g][0].data));
                    if (ordy[g]) void'(exp_q[g].pop_front());
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // mode 0: index 0 first, mode 1: index P-1 first, mode 2: from ptr upward
    function automatic int pick(logic [P-1:0] v, int mode, int ptr);
        for (int k = 0; k < P; k++) begin
            int idx;
            if (mode == 0)      idx = k;
            else if (mode == 1) idx = P - 1 - k;
            else                idx = (ptr + k) % P;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic step();
        #1;
        for (int g = 0; g < NI; g++) begin
            int           w;
            bit           load;
            logic [P-1:0] er;
            load = !m_ov[g] || ordy[g];
            w    = pick(rv[g], g, m_ptr[g]);
            er   = '0;
            if (load && w >= 0) er[w] = 1'b1;
            chk($sformatf("req_ready%0d", g), 64'(rr[g]), 64'(er));
            chk($sformatf("out_valid%0d", g), 64'(ov[g]), 64'(m_ov[g]));
            gnt[g] = (load && w >= 0) ? w : -1;
            if (load) m_ov[g] = (w >= 0);
            if (gnt[g] >= 0) begin
                exp_q[g].push_back('{idx: 2'(w), data: rd[g][w]});
                m_ptr[g] = (w + 1) % P;
            end
        end
        @(negedge clk);
    endtask

    task automatic drive_rand();
        for (int g = 0; g < NI; g++) begin
            for (int i = 0; i < P; i++) begin
                if (!rv[g][i] || gnt[g] == i) begin
                    rv[g][i] = ($urandom_range(0, 2) == 0);
                    rd[g][i] = $urandom;
                end
            end
            ordy[g] = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic model_reset();
        for (int g = 0; g < NI; g++) begin
            exp_q[g].delete();
            m_ov[g]  = 1'b0;
            m_ptr[g] = 0;
            gnt[g]   = -1;
        end
    endtask

    initial begin
        for (int g = 0; g < NI; g++) begin
            rv[g]   = 4'b1010;
            ordy[g] = 1'b1;
            for (int i = 0; i < P; i++) rd[g][i] = 32'hA000_0000 + 32'(g * 16 + i);
        end
        model_reset();
        rst = 1'b1;
        @(negedge clk);
        #1;
        for (int g = 0; g < NI; g++) begin
            chk($sformatf("rst_valid%0d", g), 64'(ov[g]), 64'd0);
            chk($sformatf("rst_ready%0d", g), 64'(rr[g]), 64'd0);
            chk($sformatf("rst_index%0d", g), 64'(oi[g]), 64'd0);
            chk($sformatf("rst_data%0d", g), 64'(od[g]), 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // channels 1 and 3 compete; winner then drops its request
        step();
        for (int g = 0; g < NI; g++) rv[g][gnt[g]] = 1'b0;
        chk("hl_first", 64'(oi[0]), 64'd1);
        chk("lh_first", 64'(oi[1]), 64'd3);
        step();
        chk("hl_second", 64'(oi[0]), 64'd3);
        chk("lh_second", 64'(oi[1]), 64'd1);

        // all channels held valid: rotating order with no bubble
        for (int g = 0; g < NI; g++) rv[g] = 4'hF;
        for (int k = 0; k < 9; k++) begin
            if (k > 0 && ov[2]) rr_seen.push_back(int'(oi[2]));
            step();
            for (int g = 0; g < NI; g++) rd[g][gnt[g]] = $urandom;
        end
        chk("rr_len", 64'(rr_seen.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("rr_seq%0d", i),
                64'((i < rr_seen.size()) ? rr_seen[i] : 99), 64'(i % 4));
        end

        for (int c = 0; c < 600; c++) begin
            if (c == 300) begin
                #3;
                rst = 1'b1;
                #1;
                for (int g = 0; g < NI; g++) begin
                    chk($sformatf("midrst_valid%0d", g), 64'(ov[g]), 64'd0);
                    chk($sformatf("midrst_ready%0d", g), 64'(rr[g]), 64'd0);
                    rv[g] = '0;
                end
                model_reset();
                @(negedge clk);
                @(negedge clk);
                rst = 1'b0;
            end
            drive_rand();
            step();
        end

        for (int g = 0; g < NI; g++) begin
            rv[g]   = '0;
            ordy[g] = 1'b1;
        end
        repeat (3) step();
        for (int g = 0; g < NI; g++) begin
            chk($sformatf("drained%0d", g), 64'(exp_q[g].size()), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/request_arbiter.md
# request_arbiter

Registered N-way arbiter that merges valid/ready request channels into one output channel and generalises the combinational priority selector. It supports fixed-priority (either direction) and round-robin modes, and holds its result in an output register until the consumer accepts it. It sits in the cpu_core wherever several producers compete for one consumer, such as writeback-port or memory-request merging.

## Interface
- `DataType`, default `cpu_core_params::cpu_data_t`: payload type.
- `PORTS`, default 4: number of request channels; at least 2.
- `MODE`, default `selector_params::HIGH_TO_LOW`:
  - `HIGH_TO_LOW`: index 0 has highest priority.
  - `LOW_TO_HIGH`: index PORTS-1 has highest priority.
  - `ROUND_ROBIN`: rotating priority.
- `IDX_W`, default `$clog2(PORTS)`: width of the winner index.

Ports:
- `clock` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `req_valid` input [PORTS]: request present per channel.
- `req_data` input DataType [PORTS]: payload per channel.
- `req_ready` output [PORTS]: channel i's request is consumed this cycle.
- `out_valid` output 1: output register holds a result.
- `out_data` output DataType: registered winning payload.
- `out_index` output IDX_W: registered winning channel index.
- `out_ready` input 1: consumer accepts the output this cycle.

## Operation
- State:
  - Output register: `out_valid`, `out_data`, `out_index`.
  - Round-robin pointer `rr_ptr` (IDX_W bits), used only in `ROUND_ROBIN`.
- `load_en = !out_valid || out_ready`. The register is empty or is draining this cycle.
- Winner selection (combinational, over channels with `req_valid` set):
  - `HIGH_TO_LOW`: lowest valid index.
  - `LOW_TO_HIGH`: highest valid index.
  - `ROUND_ROBIN`: first valid index found scanning upward from `rr_ptr`, wrapping from PORTS-1 to 0.
- `any_valid` = OR of `req_valid`.
- `req_ready[i] = load_en && any_valid && (i == winner)`. At most one bit is set, and only the winner's bit.
- On a clock edge with `load_en`:
  - `out_valid <= any_valid`.
  - If `any_valid`: `out_data <= req_data[winner]` and `out_index <= winner`.
  - If `!any_valid`: `out_data` and `out_index` hold their values.
- On a clock edge without `load_en` (`out_valid && !out_ready`): the output register holds; every `req_ready` is 0.
- Pointer update (`ROUND_ROBIN` only):
  - When a grant happens (`load_en && any_valid`): `rr_ptr <= winner + 1`, wrapping to 0 when winner is PORTS-1.
  - `rr_ptr` holds at all other times.
- Fairness: in `ROUND_ROBIN`, a channel held valid is granted within PORTS grants.
- Requesters hold `req_valid` and `req_data` stable until they see `req_ready`. The arbiter does not check this.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_index`=0, `rr_ptr`=0. All `req_ready` are 0 while `reset` is high.
- Latency: a request granted in cycle T appears on `out_valid`/`out_data` in cycle T+1.
- Throughput: one transfer per cycle when `out_ready` is held high. The register fills and drains in the same cycle.
- Combinational paths:
  - `out_ready` to `req_ready`.
  - `req_valid` to `req_ready`.
  - No path from `req_data` to any output.
- Simultaneous drain and fill: the old result leaves and the new winner loads on the same edge, with no bubble.
- Backpressure: while `out_valid && !out_ready`, the arbiter grants nothing and `rr_ptr` is frozen.
- Single requester: it wins in every mode, whatever `rr_ptr` is.
- Reset asserted mid-transfer: the held result is discarded and `out_valid` drops immediately (asynchronous). After `reset` deasserts, the first grant in `ROUND_ROBIN` starts the scan from index 0.

## Test plan
- Reset, then fixed priority: assert reset mid-stream, then release with `MODE=HIGH_TO_LOW`, PORTS=4, `req_valid`=4'b1010 (channels 1 and 3), `out_ready`=1.
  - During reset: `out_valid`=0 and `req_ready`=0.
  - After release: channel 1 is granted first (`out_index`=1 the next cycle), then channel 3 after channel 1 drops its request.
- Fixed priority, `LOW_TO_HIGH`, same stimulus: channel 3 is granted first.
- Round-robin: `MODE=ROUND_ROBIN`, all four channels held valid, `out_ready`=1 for 8 cycles. `out_index` sequence is 0,1,2,3,0,1,2,3 with no idle cycle.
- Backpressure: one result valid with `out_ready`=0 for 3 cycles while channel 2 requests.
  - During those cycles: `req_ready`=0, `out_data` stable, `rr_ptr` unchanged.
  - Raise `out_ready`: channel 2 is loaded on that same edge.
- Wrap and skip: `ROUND_ROBIN` with `rr_ptr`=3 (after a grant to channel 2) and only channels 0 and 2 valid. Channel 0 is granted and `rr_ptr` becomes 1.
